// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze and multi-cycle
// redirect flush, plus saturating stall-cycle and redirect-event counters.
module hazard_ctrl #(
    parameter int REDIR_BUBBLES = 1,   // legal range 1..15 (bub_cnt is 4 bits)
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_en,
    input  logic             id_rs2_en,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rd_en,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             feedforward_stall,
    output logic             checkpre_flush,
    output logic             exmem_stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redir_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIR    = 2'd2
    } state_t;

    localparam logic [3:0] BUB_LOAD = 4'(REDIR_BUBBLES - 1);
    localparam int         N_CNT    = 2;

    state_t     state_reg, state_next;
    logic       redir_pend_reg, redir_pend_next;
    logic [3:0] bub_cnt_reg, bub_cnt_next;

    logic       mem_busy;
    logic       redir;
    logic       load_use;
    logic       in_redir;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic [4:0] src_idx [N_CNT];
    logic [1:0] src_en;
    logic [1:0] src_hit;

    assign src_idx[0] = id_rs1;
    assign src_idx[1] = id_rs2;
    assign src_en     = {id_rs2_en, id_rs1_en};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_en[gi] & (src_idx[gi] == ex_rd);
    end

    assign mem_busy = mem_req & ~mem_ready;
    assign redir    = ex_redirect | redir_pend_reg;
    assign in_redir = (state_reg == REDIR);
    assign load_use = ex_is_load & ex_rd_en & (ex_rd != 5'd0) & (|src_hit);

    // ------------------------------------------------------------------
    // Control outputs: mem_busy > redirect > load_use > idle.
    // Forced low while reset is asserted, independent of the clock.
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall          = 1'b0;
        ifid_stall        = 1'b0;
        ifid_flush        = 1'b0;
        feedforward_stall = 1'b0;
        checkpre_flush    = 1'b0;
        exmem_stall       = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                pc_stall          = 1'b1;
                ifid_stall        = 1'b1;
                feedforward_stall = 1'b1;
                exmem_stall       = 1'b1;
            end else if (redir || in_redir) begin
                ifid_flush     = 1'b1;
                checkpre_flush = 1'b1;
            end else if (load_use) begin
                pc_stall       = 1'b1;
                ifid_stall     = 1'b1;
                checkpre_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        redir_pend_next = redir_pend_reg;
        bub_cnt_next    = bub_cnt_reg;
        if (mem_busy) begin
            // Freeze; a redirect arriving now is remembered for later.
            state_next      = MEM_WAIT;
            redir_pend_next = redir_pend_reg | ex_redirect;
        end else if (redir) begin
            redir_pend_next = 1'b0;
            bub_cnt_next    = BUB_LOAD;
            state_next      = (BUB_LOAD != 4'd0) ? REDIR : RUN;
        end else begin
            unique case (state_reg)
                REDIR: begin
                    bub_cnt_next = (bub_cnt_reg != 4'd0) ? bub_cnt_reg - 4'd1 : 4'd0;
                    state_next   = (bub_cnt_reg <= 4'd1) ? RUN : REDIR;
                end
                MEM_WAIT: begin
                    state_next = (bub_cnt_reg != 4'd0) ? REDIR : RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            redir_pend_reg <= 1'b0;
            bub_cnt_reg    <= 4'd0;
        end else begin
            state_reg      <= state_next;
            redir_pend_reg <= redir_pend_next;
            bub_cnt_reg    <= bub_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters: [0] stall cycles, [1] redirects
    // ------------------------------------------------------------------
    logic [N_CNT-1:0]            cnt_inc;
    logic [N_CNT-1:0][CNT_W-1:0] cnt_reg;
    logic [N_CNT-1:0][CNT_W-1:0] cnt_next;

    assign cnt_inc[0] = pc_stall;
    assign cnt_inc[1] = redir & ~mem_busy;

    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                cnt_next[gi] = cnt_reg[gi] + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg[gi] <= '0;
            end else begin
                cnt_reg[gi] <= cnt_next[gi];
            end
        end
    end

    assign stall_cycles = cnt_reg[0];
    assign redir_events = cnt_reg[1];

endmodule
